// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers, TX and RX engines, level irq.
// rdata is combinational, irq lags flags by one cycle; TXD writes while busy are dropped.
module uart_periph #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);
  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       txd_q, txd_d;
  logic             tx_line_q, tx_line_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rxd_q, rxd_d;
  logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [1:0]       ie_q, ie_d;
  logic             tx_done_q, tx_done_d, rx_ready_q, rx_ready_d;
  logic             frame_err_q, frame_err_d, irq_q, irq_d;
  logic             tx_done_set, rx_ready_set, frame_err_set;
  logic             sel_txd, sel_rxd, sel_con, tx_busy;
  logic [31:0]      con_word;
  logic             unused_wdata;

  assign sel_txd      = (addr == BASE_ADDR);
  assign sel_rxd      = (addr == BASE_ADDR + 32'd4);
  assign sel_con      = (addr == BASE_ADDR + 32'd8);
  assign tx_busy      = (tx_state_q != TX_IDLE);
  assign con_word     = {26'h0, frame_err_q, tx_busy, rx_ready_q, tx_done_q, ie_q};
  assign uart_tx      = tx_line_q;
  assign irq          = irq_q;
  assign unused_wdata = ^wdata[31:8];

  always_comb begin
    rdata = 32'h0;
    if (rd_en) begin
      if (sel_txd)      rdata = {24'h0, txd_q};
      else if (sel_rxd) rdata = {24'h0, rxd_q};
      else if (sel_con) rdata = con_word;
    end
  end

  // Transmit engine: the line value is registered so it changes on bit boundaries only.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    txd_d       = txd_q;
    tx_line_d   = tx_line_q;
    tx_done_set = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (wr_en && sel_txd) begin
          txd_d      = wdata[7:0];
          tx_shift_d = wdata[7:0];
          tx_cnt_d   = '0;
          tx_line_d  = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d    = '0;
          tx_done_set = 1'b1;
          tx_state_d  = TX_IDLE;
        end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Receive engine works on the synchronized line; samples are taken mid-bit.
  always_comb begin
    rx_s1_d       = uart_rx;
    rx_s2_d       = rx_s1_q;
    rx_prev_d     = rx_s2_q;
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rxd_d         = rxd_q;
    rx_ready_set  = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) begin
            rxd_d        = rx_shift_q;
            rx_ready_set = 1'b1;
          end else frame_err_set = 1'b1;
        end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Read-to-clear first, then set, so a set in the same cycle wins.
  always_comb begin
    ie_d        = (wr_en && sel_con) ? wdata[1:0] : ie_q;
    tx_done_d   = (rd_en && sel_con) ? 1'b0 : tx_done_q;
    rx_ready_d  = (rd_en && (sel_con || sel_rxd)) ? 1'b0 : rx_ready_q;
    frame_err_d = (rd_en && sel_con) ? 1'b0 : frame_err_q;
    if (tx_done_set)   tx_done_d   = 1'b1;
    if (rx_ready_set)  rx_ready_d  = 1'b1;
    if (frame_err_set) frame_err_d = 1'b1;
    irq_d = (ie_q[0] & tx_done_q) | (ie_q[1] & rx_ready_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h0;
      txd_q       <= 8'h0;
      tx_line_q   <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h0;
      rxd_q       <= 8'h0;
      ie_q        <= 2'b00;
      tx_done_q   <= 1'b0;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
      tx_line_q   <= tx_line_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rxd_q       <= rxd_d;
      ie_q        <= ie_d;
      tx_done_q   <= tx_done_d;
      rx_ready_q  <= rx_ready_d;
      frame_err_q <= frame_err_d;
      irq_q       <= irq_d;
    end
  end
endmodule

// File: tb/tb_uart_periph.sv
// Directed + randomized bench for uart_periph at 16 clocks per bit against a flag/frame model.
module tb_uart_periph;
  localparam int          CPB   = 16;
  localparam logic [31:0] BASE  = 32'h40000018;
  localparam logic [31:0] TXD_A = BASE;
  localparam logic [31:0] RXD_A = BASE + 32'd4;
  localparam logic [31:0] CON_A = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset, rd_en, wr_en, uart_rx, uart_tx, irq;
  logic [31:0] addr, wdata, rdata;

  int checks = 0;
  int errors = 0;

  // Reference state: what the register map should hold.
  logic [1:0] m_ie;
  logic       m_tx_done, m_rx_rdy, m_ferr;
  logic [7:0] m_txd, m_rxd;

  uart_periph #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wdata(wdata), .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_con(input logic busy);
    return {26'h0, m_ferr, busy, m_rx_rdy, m_tx_done, m_ie};
  endfunction

  function automatic logic m_irq();
    return (m_ie[0] & m_tx_done) | (m_ie[1] & m_rx_rdy);
  endfunction

  task automatic model_reset();
    m_ie = 2'b00; m_tx_done = 0; m_rx_rdy = 0; m_ferr = 0; m_txd = 0; m_rxd = 0;
  endtask

  // Combinational look at rdata with no clock edge under rd_en, so no side effects.
  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    addr = a; rd_en = 1'b1; #1;
    v = rdata;
    rd_en = 1'b0; addr = 32'h0; #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    addr = a; rd_en = 1'b1; #1;
    v = rdata;
    tick();
    rd_en = 1'b0; addr = 32'h0;
  endtask

  task automatic clear_con();
    logic [31:0] v;
    bus_read(CON_A, v);
    check("con_read_clear", v, m_con(1'b0));
    m_tx_done = 0; m_rx_rdy = 0; m_ferr = 0;
  endtask

  task automatic tx_frame(input logic [7:0] b, input int drop_at, input logic [7:0] drop_val,
                          input int rst_at);
    logic [9:0]  bits;
    logic [31:0] v;
    logic        aborted;
    logic        irq_before;
    bits    = {1'b1, b, 1'b0};
    aborted = 1'b0;
    bus_write(TXD_A, {24'h0, b});
    m_txd = b;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i == rst_at) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        check("rst_uart_tx", uart_tx, 1);
        peek(CON_A, v); check("rst_con", v, 0);
        peek(TXD_A, v); check("rst_txd", v, 0);
        check("rst_irq", irq, 0);
        aborted = 1'b1;
        break;
      end
      check("tx_bit", uart_tx, bits[i / CPB]);
      if (i == 0 || i == 10 * CPB - 1) begin
        peek(CON_A, v); check("tx_busy_con", v, m_con(1'b1));
      end
      if (i == drop_at) begin
        addr = TXD_A; wdata = {24'h0, drop_val}; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; addr = 32'h0; wdata = 32'h0;
      end else tick();
    end
    if (!aborted) begin
      irq_before = m_irq();
      m_tx_done  = 1'b1;
      peek(CON_A, v); check("tx_done_con", v, m_con(1'b0));
      check("tx_irq_lag", irq, irq_before);
      tick();
      check("tx_irq", irq, m_irq());
      peek(TXD_A, v); check("tx_txd", v, {24'h0, m_txd});
      for (int i = 0; i < 20; i++) begin
        check("tx_idle_line", uart_tx, 1);
        tick();
      end
      peek(CON_A, v); check("tx_idle_con", v, m_con(1'b0));
    end
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input int coll_at,
                          output int set_at);
    logic [9:0]  bits;
    logic [31:0] v;
    logic [1:0]  pre;
    bits   = {stop, b, 1'b0};
    pre    = {m_ferr, m_rx_rdy};
    set_at = -1;
    for (int i = 0; i < 11 * CPB; i++) begin
      uart_rx = (i < 10 * CPB) ? bits[i / CPB] : 1'b1;
      if (i == coll_at) begin
        addr = CON_A; rd_en = 1'b1; #1;
        v = rdata;
        check("coll_con_read", v, m_con(1'b0));
        m_tx_done = 0; m_rx_rdy = 0; m_ferr = 0;
        tick();
        rd_en = 1'b0; addr = 32'h0;
      end else begin
        peek(CON_A, v);
        if (set_at < 0 && {v[5], v[3]} != pre) set_at = i;
        tick();
      end
    end
    if (stop) begin m_rxd = b; m_rx_rdy = 1'b1; end
    else      m_ferr = 1'b1;
    peek(RXD_A, v); check("rx_rxd", v, {24'h0, m_rxd});
    peek(CON_A, v); check("rx_con", v, m_con(1'b0));
    check("rx_irq", irq, m_irq());
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    int          rx_lat, dummy;
    reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = 32'h0; wdata = 32'h0; uart_rx = 1'b1;
    model_reset();
    repeat (3) tick();
    check("reset_uart_tx", uart_tx, 1);
    check("reset_irq", irq, 0);
    reset = 1'b1;
    tick();
    peek(CON_A, v); check("reset_con", v, 0);
    peek(TXD_A, v); check("reset_txd", v, 0);
    peek(RXD_A, v); check("reset_rxd", v, 0);

    // Only the IE bits of CON are writable; unmatched addresses do nothing.
    bus_write(CON_A, 32'hFFFF_FFFF);
    m_ie = 2'b11;
    peek(CON_A, v); check("con_write_mask", v, m_con(1'b0));
    bus_write(TXD_A ^ 32'h8000_0000, 32'h55);
    tick();
    check("unmatched_no_tx", uart_tx, 1);
    peek(CON_A, v); check("unmatched_con", v, m_con(1'b0));
    peek(TXD_A + 32'd12, v); check("unmatched_rdata", v, 0);
    addr = CON_A; #1; check("rdata_no_rd_en", rdata, 0); addr = 32'h0;

    tx_frame(8'hA5, -1, 8'h00, -1);
    clear_con();
    check("irq_after_clear_lag", irq, 1);
    tick();
    check("irq_after_clear", irq, 0);

    tx_frame(8'hA5, 40, 8'h3C, -1);
    clear_con();
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom_range(255));
      tx_frame(b, (k == 0) ? int'($urandom_range(159)) : -1, 8'($urandom_range(255)), -1);
      clear_con();
    end
    tick();

    rx_frame(8'h5A, 1'b1, -1, rx_lat);
    check("rx_set_latency", 32'(rx_lat >= 148 && rx_lat <= 166), 1);
    bus_read(RXD_A, v); check("rxd_read", v, 32'h5A);
    m_rx_rdy = 0;
    check("rxd_read_irq_lag", irq, 1);
    tick();
    check("rxd_read_irq", irq, 0);
    peek(CON_A, v); check("rxd_read_con", v, m_con(1'b0));

    uart_rx = 1'b0;
    repeat (8) tick();
    uart_rx = 1'b1;
    repeat (40) tick();
    peek(CON_A, v); check("glitch_con", v, m_con(1'b0));
    peek(RXD_A, v); check("glitch_rxd", v, {24'h0, m_rxd});

    rx_frame(8'($urandom_range(255)), 1'b0, -1, dummy);
    clear_con();
    peek(CON_A, v); check("ferr_cleared", v, m_con(1'b0));

    rx_frame(8'($urandom_range(255)), 1'b1, rx_lat - 1, dummy);
    rx_frame(8'h11, 1'b1, -1, dummy);
    for (int k = 0; k < 3; k++) begin
      bus_read(RXD_A, v); check("rx_rand_read", v, {24'h0, m_rxd});
      m_rx_rdy = 0;
      tick();
      rx_frame(8'($urandom_range(255)), 1'b1, -1, dummy);
    end
    clear_con();

    tx_frame(8'($urandom_range(255)), -1, 8'h00, 5 * CPB + int'($urandom_range(CPB - 1)));
    tx_frame(8'($urandom_range(255)), -1, 8'h00, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
